// File: rtl/register_lanes_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : register_lanes_if                                      |
// | Brief    : Control/data bundle for register_lanes. The master     |
// |            drives commands and load data; the slave (the          |
// |            register) returns contents and status.                 |
// | Revision : 1.0  initial release                                   |
// +--------------------------------------------------------------------+
interface register_lanes_if #(
  parameter int W = 8,
  parameter int L = 2
);
  localparam int N  = W * L;
  localparam int CW = (L > 1) ? $clog2(L) : 1;

  logic          sclr;
  logic [N-1:0]  in;
  logic [L-1:0]  load;
  logic          inc;
  logic          rot_start;
  logic [CW-1:0] rot_cnt;
  logic          snap;
  logic          restore;
  logic [N-1:0]  out;
  logic          carry;
  logic          busy;
  logic          done;

  modport master (
    output sclr, in, load, inc, rot_start, rot_cnt, snap, restore,
    input  out, carry, busy, done
  );

  modport slave (
    input  sclr, in, load, inc, rot_start, rot_cnt, snap, restore,
    output out, carry, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/register_lanes.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : register_lanes                                         |
// | Brief    : N = W*L bit register split into L lanes of W bits.     |
// |            Supports per-lane load, whole-word increment with      |
// |            carry pulse, and a multi-cycle left rotate by lanes.   |
// |            Optional shadow register (snap/restore) is built when  |
// |            the macro REGISTER_LANES_SNAP_EN is defined.           |
// | Revision : 1.0  initial release                                   |
// +--------------------------------------------------------------------+
module register_lanes #(
  parameter int W = 8,
  parameter int L = 2
) (
  input  logic            clk,
  input  logic            clear_n,
  register_lanes_if.slave bus
);
  localparam int N  = W * L;
  localparam int CW = (L > 1) ? $clog2(L) : 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ROT  = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [N-1:0]  r_out;
  logic [N-1:0]  w_out_nxt;
  logic [CW-1:0] r_remaining;
  logic [CW-1:0] w_remaining_nxt;
  logic          r_carry;
  logic          w_carry_nxt;
  logic          r_done;
  logic          w_done_nxt;

  logic [N-1:0]  w_load_merge;
  logic [N-1:0]  w_rot;
  logic [N-1:0]  w_inc_sum;
  logic          w_inc_wrap;
  logic [N-1:0]  w_shadow;
  logic          w_restore;

  // Lanes without a load bit keep their current value.
  for (genvar gi = 0; gi < L; gi++) begin : g_lane
    assign w_load_merge[W*gi +: W] = bus.load[gi] ? bus.in[W*gi +: W] : r_out[W*gi +: W];
  end

  // One-lane left rotate: the top lane wraps around into lane 0.
  assign w_rot = {r_out[N-W-1:0], r_out[N-1:N-W]};

  // Increment with the wrap bit captured as the extra MSB.
  assign {w_inc_wrap, w_inc_sum} = {1'b0, r_out} + {{N{1'b0}}, 1'b1};

`ifdef REGISTER_LANES_SNAP_EN
  logic [N-1:0] r_shadow;

  // Shadow capture; snap samples the pre-edge out so a simultaneous restore sees the old shadow.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      r_shadow <= '0;
    end else if (bus.sclr) begin
      r_shadow <= '0;
    end else if (r_state == IDLE && bus.snap) begin
      r_shadow <= r_out;
    end
  end

  assign w_shadow  = r_shadow;
  assign w_restore = bus.restore;
`else
  logic w_unused_snap;
  assign w_unused_snap = bus.snap ^ bus.restore;
  assign w_shadow      = '0;
  assign w_restore     = 1'b0;
`endif

  // State and datapath registers; clear_n acts immediately, even mid-rotation.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      r_state     <= IDLE;
      r_out       <= '0;
      r_remaining <= '0;
      r_carry     <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_out       <= w_out_nxt;
      r_remaining <= w_remaining_nxt;
      r_carry     <= w_carry_nxt;
      r_done      <= w_done_nxt;
    end
  end

  // Next-state and datapath select in priority order: sclr, rotate, restore, load, inc.
  always_comb begin
    w_state_nxt     = r_state;
    w_out_nxt       = r_out;
    w_remaining_nxt = r_remaining;
    w_carry_nxt     = 1'b0;
    w_done_nxt      = 1'b0;

    if (bus.sclr) begin
      w_state_nxt     = IDLE;
      w_out_nxt       = '0;
      w_remaining_nxt = '0;
    end else if (r_state == ROT) begin
      w_out_nxt       = w_rot;
      w_remaining_nxt = r_remaining - CW'(1);
      if (r_remaining == CW'(1)) begin
        w_state_nxt = IDLE;
        w_done_nxt  = 1'b1;
      end
    end else if (bus.rot_start) begin
      // A zero-length rotate completes immediately without entering ROT.
      if (bus.rot_cnt == '0) begin
        w_done_nxt = 1'b1;
      end else begin
        w_state_nxt     = ROT;
        w_remaining_nxt = bus.rot_cnt;
      end
    end else if (w_restore) begin
      w_out_nxt = w_shadow;
    end else if (|bus.load) begin
      w_out_nxt = w_load_merge;
    end else if (bus.inc) begin
      w_out_nxt   = w_inc_sum;
      w_carry_nxt = w_inc_wrap;
    end
  end

  assign bus.out   = r_out;
  assign bus.carry = r_carry;
  assign bus.busy  = (r_state == ROT);
  assign bus.done  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_register_lanes.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tb_register_lanes                                      |
// | Brief    : Scoreboard bench for register_lanes, one instance with |
// |            L=2 and one with L=4 (W=8). Expected snap/restore      |
// |            results follow REGISTER_LANES_SNAP_EN.                 |
// | Revision : 1.0  initial release                                   |
// +--------------------------------------------------------------------+
module tb_register_lanes;

`ifdef REGISTER_LANES_SNAP_EN
  localparam bit SNAP = 1'b1;
`else
  localparam bit SNAP = 1'b0;
`endif

  // Control flag encodings {sclr, inc, rot_start, snap, restore}
  localparam logic [4:0] C_NONE = 5'b00000;
  localparam logic [4:0] C_SCLR = 5'b10000;
  localparam logic [4:0] C_INC  = 5'b01000;
  localparam logic [4:0] C_ROT  = 5'b00100;
  localparam logic [4:0] C_SNAP = 5'b00010;
  localparam logic [4:0] C_REST = 5'b00001;
  // Expected flag encodings {carry, busy, done}
  localparam logic [2:0] F_0 = 3'b000;
  localparam logic [2:0] F_C = 3'b100;
  localparam logic [2:0] F_B = 3'b010;
  localparam logic [2:0] F_D = 3'b001;

  typedef struct {
    logic [31:0] din;
    logic [3:0]  load;
    logic [4:0]  ctl;
    logic [1:0]  rc;
    logic [31:0] e_out;
    logic [2:0]  e_flags;
  } step_t;

  typedef struct {
    logic [31:0] out;
    logic [2:0]  flags;
  } exp_t;

  logic clk = 1'b0;
  logic clear_n = 1'b0;
  always #5 clk = ~clk;

  register_lanes_if #(.W(8), .L(2)) bus2 ();
  register_lanes_if #(.W(8), .L(4)) bus4 ();

  register_lanes #(.W(8), .L(2)) u_dut2 (.clk(clk), .clear_n(clear_n), .bus(bus2));
  register_lanes #(.W(8), .L(4)) u_dut4 (.clk(clk), .clear_n(clear_n), .bus(bus4));

  exp_t sb2[$];
  exp_t sb4[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic step_t mk(logic [31:0] din, logic [3:0] load, logic [4:0] ctl,
                               logic [1:0] rc, logic [31:0] eo, logic [2:0] ef);
    step_t s;
    s.din     = din;
    s.load    = load;
    s.ctl     = ctl;
    s.rc      = rc;
    s.e_out   = eo;
    s.e_flags = ef;
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive2(step_t s);
    bus2.in        = s.din[15:0];
    bus2.load      = s.load[1:0];
    bus2.sclr      = s.ctl[4];
    bus2.inc       = s.ctl[3];
    bus2.rot_start = s.ctl[2];
    bus2.snap      = s.ctl[1];
    bus2.restore   = s.ctl[0];
    bus2.rot_cnt   = s.rc[0:0];
  endtask

  task automatic drive4(step_t s);
    bus4.in        = s.din;
    bus4.load      = s.load;
    bus4.sclr      = s.ctl[4];
    bus4.inc       = s.ctl[3];
    bus4.rot_start = s.ctl[2];
    bus4.snap      = s.ctl[1];
    bus4.restore   = s.ctl[0];
    bus4.rot_cnt   = s.rc;
  endtask

  task automatic idle_all();
    drive2(mk(32'h0, 4'b0000, C_NONE, 2'd0, 32'h0, F_0));
    drive4(mk(32'h0, 4'b0000, C_NONE, 2'd0, 32'h0, F_0));
  endtask

  // Reset values, asynchronous clear mid-cycle, first edge after release.
  task automatic test_reset();
    exp_t        e;
    logic [34:0] obs;
    logic [34:0] req;
    idle_all();
    clear_n = 1'b0;
    tick();
    tick();
    sb2.push_back('{32'h0, F_0});
    sb4.push_back('{32'h0, F_0});
    e = sb2.pop_front();
    obs = {16'h0, bus2.out, bus2.carry, bus2.busy, bus2.done};
    req = {e.out, e.flags};
    n_checks++;
    if (obs !== req) $display("FAIL reset_l2: got out=%h cbd=%b, required out=%h cbd=%b", obs[34:3], obs[2:0], req[34:3], req[2:0]);
    else n_pass++;
    e = sb4.pop_front();
    obs = {bus4.out, bus4.carry, bus4.busy, bus4.done};
    req = {e.out, e.flags};
    n_checks++;
    if (obs !== req) $display("FAIL reset_l4: got out=%h cbd=%b, required out=%h cbd=%b", obs[34:3], obs[2:0], req[34:3], req[2:0]);
    else n_pass++;

    clear_n = 1'b1;
    drive2(mk(32'h5A5A, 4'b0011, C_NONE, 2'd0, 32'h5A5A, F_0));
    sb2.push_back('{32'h5A5A, F_0});
    tick();
    e = sb2.pop_front();
    obs = {16'h0, bus2.out, bus2.carry, bus2.busy, bus2.done};
    req = {e.out, e.flags};
    n_checks++;
    if (obs !== req) $display("FAIL reset_load: got out=%h cbd=%b, required out=%h cbd=%b", obs[34:3], obs[2:0], req[34:3], req[2:0]);
    else n_pass++;

    idle_all();
    clear_n = 1'b0;
    #2;
    sb2.push_back('{32'h0, F_0});
    e = sb2.pop_front();
    obs = {16'h0, bus2.out, bus2.carry, bus2.busy, bus2.done};
    req = {e.out, e.flags};
    n_checks++;
    if (obs !== req) $display("FAIL reset_async: got out=%h cbd=%b, required out=%h cbd=%b", obs[34:3], obs[2:0], req[34:3], req[2:0]);
    else n_pass++;

    clear_n = 1'b1;
    drive2(mk(32'h0, 4'b0000, C_INC, 2'd0, 32'h0001, F_0));
    sb2.push_back('{32'h0001, F_0});
    tick();
    e = sb2.pop_front();
    obs = {16'h0, bus2.out, bus2.carry, bus2.busy, bus2.done};
    req = {e.out, e.flags};
    n_checks++;
    if (obs !== req) $display("FAIL reset_first_edge: got out=%h cbd=%b, required out=%h cbd=%b", obs[34:3], obs[2:0], req[34:3], req[2:0]);
    else n_pass++;
  endtask

  // Per-lane load and inc suppressed by load.
  task automatic test_load();
    step_t       st[$];
    exp_t        e;
    logic [34:0] obs;
    logic [34:0] req;
    idle_all();
    st.push_back(mk(32'h1234, 4'b0011, C_NONE, 2'd0, 32'h1234, F_0));
    st.push_back(mk(32'hABCD, 4'b0001, C_NONE, 2'd0, 32'h12CD, F_0));
    st.push_back(mk(32'hABCD, 4'b0010, C_NONE, 2'd0, 32'hABCD, F_0));
    st.push_back(mk(32'hABCD, 4'b0011, C_INC,  2'd0, 32'hABCD, F_0));
    st.push_back(mk(32'h0000, 4'b0000, C_NONE, 2'd0, 32'hABCD, F_0));
    foreach (st[i]) begin
      drive2(st[i]);
      sb2.push_back('{st[i].e_out, st[i].e_flags});
      tick();
      e = sb2.pop_front();
      obs = {16'h0, bus2.out, bus2.carry, bus2.busy, bus2.done};
      req = {e.out, e.flags};
      n_checks++;
      if (obs !== req) $display("FAIL load step %0d: got out=%h cbd=%b, required out=%h cbd=%b", i, obs[34:3], obs[2:0], req[34:3], req[2:0]);
      else n_pass++;
    end
  endtask

  // Increment wrap with a one-cycle carry, and carry across lanes.
  task automatic test_inc();
    step_t       st[$];
    exp_t        e;
    logic [34:0] obs;
    logic [34:0] req;
    idle_all();
    st.push_back(mk(32'hFFFF, 4'b0011, C_NONE, 2'd0, 32'hFFFF, F_0));
    st.push_back(mk(32'h0000, 4'b0000, C_INC,  2'd0, 32'h0000, F_C));
    st.push_back(mk(32'h0000, 4'b0000, C_INC,  2'd0, 32'h0001, F_0));
    st.push_back(mk(32'h0000, 4'b0000, C_NONE, 2'd0, 32'h0001, F_0));
    st.push_back(mk(32'h00FF, 4'b0011, C_NONE, 2'd0, 32'h00FF, F_0));
    st.push_back(mk(32'h0000, 4'b0000, C_INC,  2'd0, 32'h0100, F_0));
    foreach (st[i]) begin
      drive2(st[i]);
      sb2.push_back('{st[i].e_out, st[i].e_flags});
      tick();
      e = sb2.pop_front();
      obs = {16'h0, bus2.out, bus2.carry, bus2.busy, bus2.done};
      req = {e.out, e.flags};
      n_checks++;
      if (obs !== req) $display("FAIL inc step %0d: got out=%h cbd=%b, required out=%h cbd=%b", i, obs[34:3], obs[2:0], req[34:3], req[2:0]);
      else n_pass++;
    end
  endtask

  // Synchronous clear drops carry and beats a coincident load.
  task automatic test_sclr();
    step_t       st[$];
    exp_t        e;
    logic [34:0] obs;
    logic [34:0] req;
    idle_all();
    st.push_back(mk(32'hFFFF, 4'b0011, C_NONE, 2'd0, 32'hFFFF, F_0));
    st.push_back(mk(32'h0000, 4'b0000, C_INC,  2'd0, 32'h0000, F_C));
    st.push_back(mk(32'h0000, 4'b0000, C_SCLR, 2'd0, 32'h0000, F_0));
    st.push_back(mk(32'h1234, 4'b0011, C_SCLR, 2'd0, 32'h0000, F_0));
    st.push_back(mk(32'h0000, 4'b0000, C_INC,  2'd0, 32'h0001, F_0));
    foreach (st[i]) begin
      drive2(st[i]);
      sb2.push_back('{st[i].e_out, st[i].e_flags});
      tick();
      e = sb2.pop_front();
      obs = {16'h0, bus2.out, bus2.carry, bus2.busy, bus2.done};
      req = {e.out, e.flags};
      n_checks++;
      if (obs !== req) $display("FAIL sclr step %0d: got out=%h cbd=%b, required out=%h cbd=%b", i, obs[34:3], obs[2:0], req[34:3], req[2:0]);
      else n_pass++;
    end
  endtask

  // L=2 rotate: single rotation, zero-count rotate over inc, sclr mid-rotate.
  task automatic test_rot_l2();
    step_t       st[$];
    exp_t        e;
    logic [34:0] obs;
    logic [34:0] req;
    idle_all();
    st.push_back(mk(32'h12AB, 4'b0011, C_NONE,        2'd0, 32'h12AB, F_0));
    st.push_back(mk(32'h0000, 4'b0000, C_ROT,         2'd1, 32'h12AB, F_B));
    st.push_back(mk(32'h0000, 4'b0000, C_NONE,        2'd0, 32'hAB12, F_D));
    st.push_back(mk(32'h0000, 4'b0000, C_NONE,        2'd0, 32'hAB12, F_0));
    st.push_back(mk(32'h0000, 4'b0000, C_ROT | C_INC, 2'd0, 32'hAB12, F_D));
    st.push_back(mk(32'h0000, 4'b0000, C_NONE,        2'd0, 32'hAB12, F_0));
    st.push_back(mk(32'h0000, 4'b0000, C_ROT,         2'd1, 32'hAB12, F_B));
    st.push_back(mk(32'h0000, 4'b0000, C_SCLR,        2'd0, 32'h0000, F_0));
    st.push_back(mk(32'h0000, 4'b0000, C_NONE,        2'd0, 32'h0000, F_0));
    foreach (st[i]) begin
      drive2(st[i]);
      sb2.push_back('{st[i].e_out, st[i].e_flags});
      tick();
      e = sb2.pop_front();
      obs = {16'h0, bus2.out, bus2.carry, bus2.busy, bus2.done};
      req = {e.out, e.flags};
      n_checks++;
      if (obs !== req) $display("FAIL rot_l2 step %0d: got out=%h cbd=%b, required out=%h cbd=%b", i, obs[34:3], obs[2:0], req[34:3], req[2:0]);
      else n_pass++;
    end
  endtask

  // L=4 rotate by 2 with load/inc/rot_start ignored while busy; rot_start beats load.
  task automatic test_rot_l4();
    step_t       st[$];
    exp_t        e;
    logic [34:0] obs;
    logic [34:0] req;
    idle_all();
    st.push_back(mk(32'h44332211, 4'b1111, C_NONE,        2'd0, 32'h44332211, F_0));
    st.push_back(mk(32'h00000000, 4'b0000, C_ROT,         2'd2, 32'h44332211, F_B));
    st.push_back(mk(32'h00000000, 4'b1111, C_INC | C_ROT, 2'd3, 32'h33221144, F_B));
    st.push_back(mk(32'h00000000, 4'b1111, C_NONE,        2'd0, 32'h22114433, F_D));
    st.push_back(mk(32'h00000000, 4'b0000, C_NONE,        2'd0, 32'h22114433, F_0));
    st.push_back(mk(32'h00000000, 4'b1111, C_ROT,         2'd1, 32'h22114433, F_B));
    st.push_back(mk(32'h00000000, 4'b0000, C_NONE,        2'd0, 32'h11443322, F_D));
    st.push_back(mk(32'h00000000, 4'b0000, C_NONE,        2'd0, 32'h11443322, F_0));
    foreach (st[i]) begin
      drive4(st[i]);
      sb4.push_back('{st[i].e_out, st[i].e_flags});
      tick();
      e = sb4.pop_front();
      obs = {bus4.out, bus4.carry, bus4.busy, bus4.done};
      req = {e.out, e.flags};
      n_checks++;
      if (obs !== req) $display("FAIL rot_l4 step %0d: got out=%h cbd=%b, required out=%h cbd=%b", i, obs[34:3], obs[2:0], req[34:3], req[2:0]);
      else n_pass++;
    end
  endtask

  // Asynchronous clear in the middle of a 3-step rotation, then a fresh rotate.
  task automatic test_rot_reset();
    step_t       st[$];
    step_t       st2[$];
    exp_t        e;
    logic [34:0] obs;
    logic [34:0] req;
    idle_all();
    st.push_back(mk(32'h44332211, 4'b1111, C_NONE, 2'd0, 32'h44332211, F_0));
    st.push_back(mk(32'h00000000, 4'b0000, C_ROT,  2'd3, 32'h44332211, F_B));
    st.push_back(mk(32'h00000000, 4'b0000, C_NONE, 2'd0, 32'h33221144, F_B));
    foreach (st[i]) begin
      drive4(st[i]);
      sb4.push_back('{st[i].e_out, st[i].e_flags});
      tick();
      e = sb4.pop_front();
      obs = {bus4.out, bus4.carry, bus4.busy, bus4.done};
      req = {e.out, e.flags};
      n_checks++;
      if (obs !== req) $display("FAIL rot_reset pre step %0d: got out=%h cbd=%b, required out=%h cbd=%b", i, obs[34:3], obs[2:0], req[34:3], req[2:0]);
      else n_pass++;
    end

    clear_n = 1'b0;
    #2;
    sb4.push_back('{32'h0, F_0});
    e = sb4.pop_front();
    obs = {bus4.out, bus4.carry, bus4.busy, bus4.done};
    req = {e.out, e.flags};
    n_checks++;
    if (obs !== req) $display("FAIL rot_reset async: got out=%h cbd=%b, required out=%h cbd=%b", obs[34:3], obs[2:0], req[34:3], req[2:0]);
    else n_pass++;
    clear_n = 1'b1;

    st2.push_back(mk(32'h00000000, 4'b0000, C_NONE, 2'd0, 32'h00000000, F_0));
    st2.push_back(mk(32'h04030201, 4'b1111, C_NONE, 2'd0, 32'h04030201, F_0));
    st2.push_back(mk(32'h00000000, 4'b0000, C_ROT,  2'd1, 32'h04030201, F_B));
    st2.push_back(mk(32'h00000000, 4'b0000, C_NONE, 2'd0, 32'h03020104, F_D));
    foreach (st2[i]) begin
      drive4(st2[i]);
      sb4.push_back('{st2[i].e_out, st2[i].e_flags});
      tick();
      e = sb4.pop_front();
      obs = {bus4.out, bus4.carry, bus4.busy, bus4.done};
      req = {e.out, e.flags};
      n_checks++;
      if (obs !== req) $display("FAIL rot_reset post step %0d: got out=%h cbd=%b, required out=%h cbd=%b", i, obs[34:3], obs[2:0], req[34:3], req[2:0]);
      else n_pass++;
    end
  endtask

  // Shadow snap/restore, simultaneous snap+restore, sclr clearing the shadow.
  task automatic test_snap();
    step_t       st[$];
    exp_t        e;
    logic [34:0] obs;
    logic [34:0] req;
    idle_all();
    st.push_back(mk(32'h1111, 4'b0011, C_NONE,          2'd0, 32'h1111, F_0));
    st.push_back(mk(32'h0000, 4'b0000, C_SNAP,          2'd0, 32'h1111, F_0));
    st.push_back(mk(32'h2222, 4'b0011, C_NONE,          2'd0, 32'h2222, F_0));
    st.push_back(mk(32'h0000, 4'b0000, C_REST,          2'd0, SNAP ? 32'h1111 : 32'h2222, F_0));
    st.push_back(mk(32'h3333, 4'b0011, C_NONE,          2'd0, 32'h3333, F_0));
    st.push_back(mk(32'h0000, 4'b0000, C_SNAP | C_REST, 2'd0, SNAP ? 32'h1111 : 32'h3333, F_0));
    st.push_back(mk(32'h4444, 4'b0011, C_NONE,          2'd0, 32'h4444, F_0));
    st.push_back(mk(32'h0000, 4'b0000, C_REST,          2'd0, SNAP ? 32'h3333 : 32'h4444, F_0));
    st.push_back(mk(32'h0000, 4'b0000, C_SCLR,          2'd0, 32'h0000, F_0));
    st.push_back(mk(32'h5555, 4'b0011, C_NONE,          2'd0, 32'h5555, F_0));
    st.push_back(mk(32'h0000, 4'b0000, C_REST,          2'd0, SNAP ? 32'h0000 : 32'h5555, F_0));
    st.push_back(mk(32'h6666, 4'b0011, C_REST,          2'd0, SNAP ? 32'h0000 : 32'h6666, F_0));
    foreach (st[i]) begin
      drive2(st[i]);
      sb2.push_back('{st[i].e_out, st[i].e_flags});
      tick();
      e = sb2.pop_front();
      obs = {16'h0, bus2.out, bus2.carry, bus2.busy, bus2.done};
      req = {e.out, e.flags};
      n_checks++;
      if (obs !== req) $display("FAIL snap step %0d: got out=%h cbd=%b, required out=%h cbd=%b", i, obs[34:3], obs[2:0], req[34:3], req[2:0]);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_inc();
    test_sclr();
    test_rot_l2();
    test_rot_l4();
    test_rot_reset();
    test_snap();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
